// File: rtl/relay_credit_tx_if.sv
// Link-side bundle for relay_credit_tx: the upstream FWFT pop interface, the
// outbound registered link and the credit return, all in one clock domain.
// master = the transmitter, slave = the environment around it.
interface relay_credit_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 8,
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
);
  logic                  en;
  logic                  in_empty_n;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_read;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  credit_in;
  logic [CNT_WIDTH-1:0]  credits;
  logic                  credit_overflow;

  modport master (
    input  en, in_empty_n, in_dout, credit_in,
    output in_read, out_valid, out_data, credits, credit_overflow
  );

  modport slave (
    output en, in_empty_n, in_dout, credit_in,
    input  in_read, out_valid, out_data, credits, credit_overflow
  );
endinterface

// File: rtl/relay_credit_tx.sv
// Credit-based transmitter: pops a FWFT FIFO and launches one word per cycle
// onto a registered link, but only while the remote buffer has a free slot.
// The per-cycle state (IDLE / SEND / STARVED) is implied by en, in_empty_n
// and the credit count, so no explicit state register is kept.
module relay_credit_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 8,
  // Derived from CREDITS; must match the interface instance.
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
  input logic             clk,
  input logic             reset,
  relay_credit_tx_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] CREDIT_ONE = CNT_WIDTH'(1);

  logic                  has_credit;
  logic                  send;
  logic [CNT_WIDTH-1:0]  credits_reg;
  logic [CNT_WIDTH-1:0]  credits_next;
  logic                  overflow_reg;
  logic                  overflow_next;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;

  // Launch decision: depends only on the registered count, never on credit_in,
  // so a returned credit becomes usable one cycle after it arrives.
  always_comb begin
    has_credit = (credits_reg != '0);
    send       = bus.en & bus.in_empty_n & has_credit & ~reset;
  end

  // Credit bookkeeping: a send and a return in the same cycle cancel out; a
  // return at a full count is refused and flagged instead of wrapping.
  always_comb begin
    credits_next  = credits_reg;
    overflow_next = overflow_reg;
    case ({send, bus.credit_in})
      2'b10: credits_next = credits_reg - CREDIT_ONE;
      2'b01: begin
        if (credits_reg == CREDIT_MAX) begin
          overflow_next = 1'b1;
        end else begin
          credits_next = credits_reg + CREDIT_ONE;
        end
      end
      default: credits_next = credits_reg;
    endcase
  end

  // Link register and counters; reset drops any in-flight word and refills
  // the credit pool because the remote buffer is reset alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      credits_reg   <= CREDIT_MAX;
      overflow_reg  <= 1'b0;
    end else begin
      out_valid_reg <= send;
      if (send) begin
        out_data_reg <= bus.in_dout;
      end
      credits_reg  <= credits_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.in_read         = send;
  assign bus.out_valid       = out_valid_reg;
  assign bus.out_data        = out_data_reg;
  assign bus.credits         = credits_reg;
  assign bus.credit_overflow = overflow_reg;

endmodule

// File: tb/tb_relay_credit_tx.sv
// Directed bench for relay_credit_tx. Four instances with different CREDITS
// share one clock and reset; each scenario exercises one of them.
module tb_relay_credit_tx;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  relay_credit_tx_if #(.DATA_WIDTH(8), .CREDITS(8)) if8 ();
  relay_credit_tx_if #(.DATA_WIDTH(8), .CREDITS(4)) if4 ();
  relay_credit_tx_if #(.DATA_WIDTH(8), .CREDITS(1)) if1 ();
  relay_credit_tx_if #(.DATA_WIDTH(8), .CREDITS(2)) if2 ();

  relay_credit_tx #(.DATA_WIDTH(8), .CREDITS(8)) u8 (.clk(clk), .reset(reset), .bus(if8));
  relay_credit_tx #(.DATA_WIDTH(8), .CREDITS(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
  relay_credit_tx #(.DATA_WIDTH(8), .CREDITS(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  relay_credit_tx #(.DATA_WIDTH(8), .CREDITS(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // FWFT upstream models for the CREDITS=4 and CREDITS=1 instances
  logic [7:0] w4 [16];
  logic [7:0] w1 [16];
  int rd4 = 0;
  int rd1 = 0;
  int n4  = 0;
  int n1  = 0;

  always @(posedge clk) if (if4.in_read === 1'b1) rd4 <= rd4 + 1;
  always @(posedge clk) if (if1.in_read === 1'b1) rd1 <= rd1 + 1;

  assign if4.in_empty_n = (rd4 < n4);
  assign if4.in_dout    = w4[rd4[3:0]];
  assign if1.in_empty_n = (rd1 < n1);
  assign if1.in_dout    = w1[rd1[3:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    if8.en = 1'b0; if8.credit_in = 1'b0; if8.in_empty_n = 1'b0; if8.in_dout = 8'h00;
    if4.en = 1'b0; if4.credit_in = 1'b0;
    if1.en = 1'b0; if1.credit_in = 1'b0;
    if2.en = 1'b0; if2.credit_in = 1'b0; if2.in_empty_n = 1'b0; if2.in_dout = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w4[i] = 8'(8'h11 + i);
      w1[i] = 8'(8'h21 + i);
    end
    n4 = 6;
    n1 = 8;

    // ---- asynchronous reset asserted mid-cycle ----
    tick; tick;
    #3;
    if8.en = 1'b1; if8.in_empty_n = 1'b1; if8.in_dout = 8'hEE;
    reset = 1'b1;
    #1;
    chk("reset_valid", if8.out_valid, 1'b0);
    chk("reset_data", if8.out_data, 8'h00);
    chk("reset_credits8", if8.credits, 8);
    chk("reset_ovf", if8.credit_overflow, 1'b0);
    chk("reset_in_read", if8.in_read, 1'b0);
    chk("reset_credits4", if4.credits, 4);
    chk("reset_credits1", if1.credits, 1);
    chk("reset_credits2", if2.credits, 2);
    tick;
    chk("reset_hold_in_read", if8.in_read, 1'b0);
    chk("reset_hold_valid", if8.out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    if8.en = 1'b0; if8.in_empty_n = 1'b0;
    tick;
    chk("post_reset_valid", if8.out_valid, 1'b0);
    chk("post_reset_credits", if8.credits, 8);

    // ---- burst without credit returns, CREDITS=4 ----
    if4.en = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      $display("burst cycle %0d: in_read=%0b credits=%0d", k, if4.in_read, if4.credits);
      chk("burst_in_read", if4.in_read, (k < 4) ? 1'b1 : 1'b0);
      chk("burst_credits", if4.credits, (k < 4) ? 4 - k : 0);
      tick;
      chk("burst_valid", if4.out_valid, (k < 4) ? 1'b1 : 1'b0);
      chk("burst_data", if4.out_data, (k < 4) ? 8'(8'h11 + k) : 8'h14);
      #1;
    end
    chk("burst_pops", rd4, 4);
    chk("burst_starved_head", if4.in_empty_n, 1'b1);
    if4.en = 1'b0;

    // ---- steady state with CREDITS=1, a credit returned every cycle ----
    if1.en = 1'b1;
    if1.credit_in = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("steady_in_read", if1.in_read, 1'b1);
      chk("steady_credits", if1.credits, 1);
      tick;
      $display("steady word %0d: out_valid=%0b out_data=%0h", k, if1.out_valid, if1.out_data);
      chk("steady_valid", if1.out_valid, 1'b1);
      chk("steady_data", if1.out_data, 8'(8'h21 + k));
      #1;
    end
    if1.credit_in = 1'b0;
    if1.en = 1'b0;
    tick;
    chk("steady_end_credits", if1.credits, 1);
    chk("steady_end_ovf", if1.credit_overflow, 1'b0);
    chk("steady_end_valid", if1.out_valid, 1'b0);
    chk("steady_pops", rd1, 8);

    // ---- drain CREDITS=8 to zero, then release one starved word ----
    if8.en = 1'b1;
    if8.in_empty_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if8.in_dout = 8'(8'h30 + k);
      #1;
      chk("drain_in_read", if8.in_read, 1'b1);
      tick;
      chk("drain_data", if8.out_data, 8'(8'h30 + k));
      chk("drain_credits", if8.credits, 7 - k);
    end
    if8.in_dout = 8'hAB;
    #1;
    chk("starved_in_read", if8.in_read, 1'b0);
    tick;
    chk("starved_valid", if8.out_valid, 1'b0);
    chk("starved_credits", if8.credits, 0);
    if8.credit_in = 1'b1;
    #1;
    chk("release_no_comb_path", if8.in_read, 1'b0);
    tick;
    if8.credit_in = 1'b0;
    chk("release_credits1", if8.credits, 1);
    #1;
    chk("release_in_read", if8.in_read, 1'b1);
    chk("release_valid_pre", if8.out_valid, 1'b0);
    tick;
    $display("release: out_valid=%0b out_data=%0h credits=%0d", if8.out_valid, if8.out_data, if8.credits);
    chk("release_valid", if8.out_valid, 1'b1);
    chk("release_data", if8.out_data, 8'hAB);
    chk("release_credits0", if8.credits, 0);
    if8.in_empty_n = 1'b0;
    #1;
    chk("release_idle_in_read", if8.in_read, 1'b0);

    // ---- overflow on CREDITS=2 ----
    if2.credit_in = 1'b1;
    #1;
    chk("ovf_before", if2.credit_overflow, 1'b0);
    tick;
    if2.credit_in = 1'b0;
    chk("ovf_credits", if2.credits, 2);
    chk("ovf_flag", if2.credit_overflow, 1'b1);
    chk("ovf_valid", if2.out_valid, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("ovf_sticky", if2.credit_overflow, 1'b1);
      chk("ovf_sticky_credits", if2.credits, 2);
    end

    // ---- credits accepted with en=0, then enable drop mid-burst ----
    if8.en = 1'b0;
    if8.credit_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("en0_credit_count", if8.credits, k + 1);
    end
    if8.credit_in = 1'b0;
    if8.en = 1'b1;
    if8.in_empty_n = 1'b1;
    if8.in_dout = 8'h51;
    #1;
    chk("mid_in_read", if8.in_read, 1'b1);
    tick;
    chk("mid_data", if8.out_data, 8'h51);
    chk("mid_credits", if8.credits, 2);
    if8.en = 1'b0;
    if8.in_dout = 8'h52;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("en_drop_in_read", if8.in_read, 1'b0);
      tick;
      chk("en_drop_valid", if8.out_valid, 1'b0);
      chk("en_drop_credits", if8.credits, 2);
    end
    if8.en = 1'b1;
    #1;
    chk("resume_in_read", if8.in_read, 1'b1);
    tick;
    chk("resume_data", if8.out_data, 8'h52);
    chk("resume_credits", if8.credits, 1);

    // ---- reset with credits=1 while a send is pending ----
    if8.in_dout = 8'h53;
    #1;
    chk("pre_reset_in_read", if8.in_read, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_valid", if8.out_valid, 1'b0);
    chk("mid_reset_data", if8.out_data, 8'h00);
    chk("mid_reset_credits", if8.credits, 8);
    chk("mid_reset_in_read", if8.in_read, 1'b0);
    chk("mid_reset_ovf_clear", if2.credit_overflow, 1'b0);
    tick;
    chk("mid_reset_hold_valid", if8.out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    if8.en = 1'b0;
    if8.in_empty_n = 1'b0;
    tick;
    chk("after_reset_valid", if8.out_valid, 1'b0);
    chk("after_reset_credits", if8.credits, 8);
    if8.en = 1'b1;
    if8.in_empty_n = 1'b1;
    if8.in_dout = 8'h54;
    #1;
    chk("after_reset_in_read", if8.in_read, 1'b1);
    tick;
    chk("after_reset_data", if8.out_data, 8'h54);
    chk("after_reset_credits7", if8.credits, 7);
    if8.en = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
